fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32I core: owns the PC, drives the instruction-memory (I-cache) read handshake and holds the IF/ID pipeline register. The IF/ID register's decode fields drive the control-word decoder directly. Handles downstream stalls, back-pressure while a fetch is in flight, and EX-stage redirects (taken branch, `jal`, `jalr`), discarding wrong-path fetches.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the fetch path.
// Opcodes, fetch FSM states and IF-stage constants.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP,
        HELD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h00000060;
    localparam logic [31:0] NOP_INSTR        = 32'h00000013;

    function automatic logic [31:0] pc_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush-to-NOP.
// Decode fields are plain slices of the held instruction.
module if_id_reg
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output rv32i_opcode opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

    assign opcode = rv32i_opcode'(instr[6:0]);
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, I-cache handshake, skid entry and IF/ID.
// Redirects flush IF/ID and discard any in-flight wrong-path fetch.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output rv32i_opcode if_id_opcode,
    output logic [2:0]  if_id_funct3,
    output logic [6:0]  if_id_funct7,
    output logic [4:0]  if_id_rs1,
    output logic [4:0]  if_id_rs2,
    output logic [4:0]  if_id_rd
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fetch_entry_t skid_q, skid_d;

    logic        accept;
    logic        load;
    logic [31:0] load_pc;
    logic [31:0] load_instr;
    logic [31:0] pc_next;

    assign accept  = !(if_id_valid && stall);
    assign pc_next = pc_q + 32'd4;

    // pc_q is kept word-aligned, so it is the request address as-is
    assign imem_address = pc_q;
    assign imem_read    = !rst &&
                          (((state_q == IDLE) && accept && !redirect) ||
                           (state_q == BUSY) || (state_q == DROP));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        load       = 1'b0;
        load_pc    = pc_q;
        load_instr = imem_rdata;
        if (redirect) begin
            pc_d = pc_align(redirect_pc);
            if ((state_q == BUSY) || (state_q == DROP)) begin
                state_d = imem_resp ? IDLE : DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (imem_read) begin
                        if (imem_resp) begin
                            load = 1'b1;
                            pc_d = pc_next;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (imem_resp) begin
                        pc_d = pc_next;
                        if (accept) begin
                            load    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            skid_d.pc    = pc_q;
                            skid_d.instr = imem_rdata;
                            state_d      = HELD;
                        end
                    end
                end
                DROP: begin
                    if (imem_resp) begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (accept) begin
                        load       = 1'b1;
                        load_pc    = skid_q.pc;
                        load_instr = skid_q.instr;
                        state_d    = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= pc_align(PC_RESET);
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (redirect),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .opcode     (if_id_opcode),
        .funct3     (if_id_funct3),
        .funct7     (if_id_funct7),
        .rs1        (if_id_rs1),
        .rs2        (if_id_rs2),
        .rd         (if_id_rd)
    );

endmodule
